// File: rtl/prefetch_pkg.sv
// Shared types and constants for the instruction prefetch unit.
// No logic; consumed at elaboration only.
// Not applicable: no handshakes live here.
package prefetch_pkg;

  // Fetch FSM: issue a bus read, drain the holding buffer, or wait out a stale read.
  typedef enum logic [1:0] {
    REQ     = 2'd0,
    PUSH    = 2'd1,
    DISCARD = 2'd2
  } state_t;

  localparam logic [15:0] DEF_RESET_CS = 16'hffff;
  localparam logic [15:0] DEF_RESET_IP = 16'h0000;

  // Real-mode physical address width (segment*16 + offset, 1 MiB space).
  localparam int PHYS_W = 20;

endpackage

// File: rtl/prefetch_if.sv
// Bundles the prefetch unit's control, byte-FIFO write and memory-read signals.
// No logic, no latency.
// Backpressure: fifo_full from the FIFO; mem_ack completes a held mem_access request.
interface prefetch_if;
  import prefetch_pkg::*;

  logic                load_new_ip;
  logic [15:0]         new_cs;
  logic [15:0]         new_ip;

  logic                fifo_wr_en;
  logic [7:0]          fifo_wr_data;
  logic                fifo_full;
  logic                fifo_reset;

  logic                mem_access;
  logic                mem_ack;
  logic [PHYS_W-2:0]   mem_address;
  logic [15:0]         mem_data;

  // The prefetch unit itself.
  modport master (
    input  load_new_ip, new_cs, new_ip, fifo_full, mem_ack, mem_data,
    output fifo_wr_en, fifo_wr_data, fifo_reset, mem_access, mem_address
  );

  // Branch source, FIFO and memory side.
  modport slave (
    output load_new_ip, new_cs, new_ip, fifo_full, mem_ack, mem_data,
    input  fifo_wr_en, fifo_wr_data, fifo_reset, mem_access, mem_address
  );

endinterface

// File: rtl/prefetch_phys_addr_calc.sv
// Segment:offset to 20-bit physical address (seg*16 + off, carry out of bit 19 dropped).
// Purely combinational, zero latency.
// No handshake; also reused by the load/store unit.
module phys_addr_calc
  import prefetch_pkg::*;
(
  input  logic [15:0]       seg,
  input  logic [15:0]       off,
  output logic [PHYS_W-1:0] phys
);

  // Both operands are 20 bits wide, so the sum wraps naturally at 1 MiB.
  assign phys = {seg, 4'h0} + {4'h0, off};

endmodule

// File: rtl/prefetch_unit.sv
// Fetches 16-bit words at CS:IP, splits them into bytes and pushes them in program order.
// Latency: first byte is pushed the cycle after mem_ack; then 1 byte/cycle.
// Backpressure: fifo_full stalls pushing indefinitely; optional PREFETCH_STALL_COUNT_EN adds stall_count.
module prefetch_unit
  import prefetch_pkg::*;
#(
  parameter logic [15:0] RESET_CS = DEF_RESET_CS,
  parameter logic [15:0] RESET_IP = DEF_RESET_IP
) (
  input  logic        clk,
  input  logic        reset,
  prefetch_if.master  bus
`ifdef PREFETCH_STALL_COUNT_EN
  ,
  output logic [15:0] stall_count
`endif
);

  state_t              state;
  state_t              state_nxt;
  logic [15:0]         fetch_cs;
  logic [15:0]         fetch_ip;
  logic [15:0]         buf_dat;
  logic [1:0]          buf_vld;
  logic [PHYS_W-2:0]   hold_addr;
  logic [PHYS_W-1:0]   phys;

  logic                bus_busy;
  logic                push_go;
  logic                last_byte;

  phys_addr_calc u_phys (
    .seg  (fetch_cs),
    .off  (fetch_ip),
    .phys (phys)
  );

  // A read is on the bus in REQ and DISCARD; the bus cannot abort it.
  assign bus_busy  = (state == REQ) || (state == DISCARD);
  // A push happens only when the FIFO has room and no branch overrides it.
  assign push_go   = (state == PUSH) && !bus.fifo_full && !bus.load_new_ip;
  // In PUSH at least one byte is valid; with fewer than two, this push empties the buffer.
  assign last_byte = !(buf_vld[0] && buf_vld[1]);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= REQ;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; a branch overrides everything, but a live read must still be waited out.
  always_comb begin
    state_nxt = state;
    if (bus.load_new_ip) begin
      state_nxt = (bus_busy && !bus.mem_ack) ? DISCARD : REQ;
    end else begin
      case (state)
        REQ:     if (bus.mem_ack) state_nxt = PUSH;
        PUSH:    if (push_go && last_byte) state_nxt = REQ;
        DISCARD: if (bus.mem_ack) state_nxt = REQ;
        default: state_nxt = REQ;
      endcase
    end
  end

  // Outputs; everything is held quiet while reset is asserted.
  always_comb begin
    bus.mem_access   = !reset && bus_busy;
    // DISCARD keeps presenting the stale request's address until it is acknowledged.
    bus.mem_address  = (state == DISCARD) ? hold_addr : phys[PHYS_W-1:1];
    bus.fifo_wr_en   = !reset && push_go;
    bus.fifo_wr_data = buf_vld[0] ? buf_dat[7:0] : buf_dat[15:8];
    bus.fifo_reset   = !reset && bus.load_new_ip;
  end

  // Fetch pointer, holding buffer and stale-request address.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_cs  <= RESET_CS;
      fetch_ip  <= RESET_IP;
      buf_dat   <= 16'h0000;
      buf_vld   <= 2'b00;
      hold_addr <= '0;
    end else if (bus.load_new_ip) begin
      fetch_cs <= bus.new_cs;
      fetch_ip <= bus.new_ip;
      buf_vld  <= 2'b00;
      // Capture the in-flight address before CS:IP changes under it.
      if (state == REQ) begin
        hold_addr <= phys[PHYS_W-1:1];
      end
    end else begin
      if ((state == REQ) && bus.mem_ack) begin
        buf_dat <= bus.mem_data;
        // An odd start address only wants the high byte of the word.
        buf_vld <= phys[0] ? 2'b10 : 2'b11;
      end
      if (push_go) begin
        fetch_ip <= fetch_ip + 16'd1;
        if (buf_vld[0]) begin
          buf_vld[0] <= 1'b0;
        end else begin
          buf_vld[1] <= 1'b0;
        end
      end
    end
  end

`ifdef PREFETCH_STALL_COUNT_EN
  // Saturating count of cycles spent blocked in PUSH by a full FIFO.
  always_ff @(posedge clk) begin
    if (reset || bus.load_new_ip) begin
      stall_count <= 16'h0000;
    end else if ((state == PUSH) && bus.fifo_full && (stall_count != 16'hffff)) begin
      stall_count <= stall_count + 16'd1;
    end
  end
`endif

endmodule
